// File: rtl/pam_n_slicer.sv
// PAM-N slicer: thresholds a signed sample into a (Gray-coded) level index,
// flags samples that land close to a decision threshold, and buffers results.
module pam_n_slicer #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int BITS_PER_SYMBOL   = 2,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int GRAY_EN           = 1,
  parameter int MARGIN            = 8,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [SIGNAL_RESOLUTION-1:0] voltage_level_in,
  input  logic                                voltage_level_in_valid,
  output logic                                voltage_level_in_ready,
  output logic [BITS_PER_SYMBOL-1:0]          symbol_out,
  output logic                                low_margin_out,
  output logic                                symbol_out_valid,
  input  logic                                symbol_out_ready,
  output logic [15:0]                         margin_count,
  input  logic                                count_clear
);

  localparam int M     = 1 << BITS_PER_SYMBOL;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  function automatic int threshold(input int j);
    return (2 * j - (M - 2)) * SYMBOL_SEPERATION / 2;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  int                         w_vin;
  logic [BITS_PER_SYMBOL-1:0] w_idx;
  logic [BITS_PER_SYMBOL-1:0] w_sym;
  logic                       w_low_margin;
  logic                       w_accept;
  logic                       w_push;
  logic                       w_pop;

  logic                       r_run;
  logic                       r_s1_valid;
  logic [BITS_PER_SYMBOL-1:0] r_s1_sym;
  logic                       r_s1_lm;
  logic [BITS_PER_SYMBOL-1:0] r_mem_sym [FIFO_DEPTH];
  logic                       r_mem_lm  [FIFO_DEPTH];
  logic [PTR_W-1:0]           r_wptr;
  logic [PTR_W-1:0]           r_rptr;
  logic [CNT_W-1:0]           r_count;
  logic [15:0]                r_margin_count;

  assign w_vin = int'(voltage_level_in);

  // The level index is simply how many thresholds the sample sits at or above.
  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    w_idx        = '0;
    w_low_margin = 1'b0;
    for (int j = 0; j < M - 1; j++) begin
      if (w_vin >= threshold(j)) w_idx = w_idx + BITS_PER_SYMBOL'(1);
      if ((w_vin - threshold(j) < MARGIN) && (w_vin - threshold(j) > -MARGIN))
        w_low_margin = 1'b1;
    end
  end

  assign w_sym = (GRAY_EN != 0) ? (w_idx ^ (w_idx >> 1)) : w_idx;

  // Stage 1 is counted against capacity, so a pushed result always finds room.
  assign voltage_level_in_ready = r_run &&
                                  ((int'(r_count) + int'(r_s1_valid)) < FIFO_DEPTH);
  assign w_accept         = voltage_level_in_valid && voltage_level_in_ready;
  assign symbol_out_valid = (r_count != '0);
  assign w_pop            = symbol_out_valid && symbol_out_ready;
  assign w_push           = r_s1_valid;

  assign symbol_out     = symbol_out_valid ? r_mem_sym[r_rptr] : '0;
  assign low_margin_out = symbol_out_valid ? r_mem_lm[r_rptr]  : 1'b0;
  assign margin_count   = r_margin_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run      <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_sym   <= '0;
      r_s1_lm    <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_run      <= 1'b1;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sym <= w_sym;
        r_s1_lm  <= w_low_margin;
      end
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count and the output mask keep stale entries invisible.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem_sym[r_wptr] <= r_s1_sym;
      r_mem_lm[r_wptr]  <= r_s1_lm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || count_clear) begin
      r_margin_count <= '0;
    end else if (w_pop && low_margin_out && (r_margin_count != 16'hFFFF)) begin
      r_margin_count <= r_margin_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pam_n_slicer.sv
// Self-checking bench for pam_n_slicer: table-driven vectors through a scoreboard,
// plus hand-written sequences for latency, backpressure, saturation and reset.
module tb_pam_n_slicer;

  typedef struct {
    logic signed [7:0] vin;
    logic [2:0]        sym;
    logic              lm;
  } vec_t;

  typedef struct {
    logic [2:0] sym;
    logic       lm;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] vin;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        sym_out;
  logic              lm_out;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       mcount;
  logic              count_clear;

  logic signed [7:0] vin8;
  logic              in_valid8;
  logic              in_ready8;
  logic [2:0]        sym_out8;
  logic              lm_out8;
  logic              out_valid8;
  logic [15:0]       mcount8;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q4[$];
  exp_t q8[$];
  vec_t tbl[17];
  vec_t tbl8[6];

  always #5 clk = ~clk;

  pam_n_slicer dut (
    .clk(clk), .rst(rst),
    .voltage_level_in(vin), .voltage_level_in_valid(in_valid),
    .voltage_level_in_ready(in_ready),
    .symbol_out(sym_out), .low_margin_out(lm_out),
    .symbol_out_valid(out_valid), .symbol_out_ready(out_ready),
    .margin_count(mcount), .count_clear(count_clear)
  );

  pam_n_slicer #(
    .SIGNAL_RESOLUTION(8), .BITS_PER_SYMBOL(3), .SYMBOL_SEPERATION(32),
    .GRAY_EN(0), .MARGIN(8), .FIFO_DEPTH(4)
  ) dut8 (
    .clk(clk), .rst(rst),
    .voltage_level_in(vin8), .voltage_level_in_valid(in_valid8),
    .voltage_level_in_ready(in_ready8),
    .symbol_out(sym_out8), .low_margin_out(lm_out8),
    .symbol_out_valid(out_valid8), .symbol_out_ready(1'b1),
    .margin_count(mcount8), .count_clear(1'b0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Output scoreboards: an entry is consumed on every handshake the DUT will complete.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q4.size() == 0) check("unexpected_symbol", 32'(sym_out), 32'hDEAD);
      else begin
        check("symbol", 32'(sym_out), 32'(q4[0].sym));
        check("low_margin", 32'(lm_out), 32'(q4[0].lm));
        void'(q4.pop_front());
      end
    end
    if (!rst && out_valid8) begin
      if (q8.size() == 0) check("unexpected_symbol8", 32'(sym_out8), 32'hDEAD);
      else begin
        check("symbol8", 32'(sym_out8), 32'(q8[0].sym));
        check("low_margin8", 32'(lm_out8), 32'(q8[0].lm));
        void'(q8.pop_front());
      end
    end
  end

  task automatic send(input vec_t v, input bit rnd);
    bit accepted = 1'b0;
    vin      = v.vin;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !accepted; c++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        q4.push_back('{sym: v.sym, lm: v.lm});
        accepted = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (q4.size() == 0 && !out_valid) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("drain", 32'(done), 32'd1);
  endtask

  task automatic clear_count();
    count_clear = 1'b1;
    @(posedge clk); #1;
    count_clear = 1'b0;
    check("count_clear", 32'(mcount), 32'd0);
  endtask

  initial begin
    int exp_lm;
    int acc;
    // Defaults: levels -84/-28/28/84, thresholds -56/0/56, Gray 00/01/11/10, margin 8.
    tbl[0]  = '{-84,  3'b000, 1'b0};
    tbl[1]  = '{-28,  3'b001, 1'b0};
    tbl[2]  = '{28,   3'b011, 1'b0};
    tbl[3]  = '{84,   3'b010, 1'b0};
    tbl[4]  = '{-128, 3'b000, 1'b0}; // idx 0
    tbl[5]  = '{-56,  3'b001, 1'b1}; // idx 1 (equal to threshold -> upper level)
    tbl[6]  = '{0,    3'b011, 1'b1}; // idx 2
    tbl[7]  = '{55,   3'b011, 1'b1}; // idx 2
    tbl[8]  = '{127,  3'b010, 1'b0}; // idx 3
    tbl[9]  = '{-57,  3'b000, 1'b1};
    tbl[10] = '{-49,  3'b001, 1'b1};
    tbl[11] = '{-48,  3'b001, 1'b0};
    tbl[12] = '{8,    3'b011, 1'b0};
    tbl[13] = '{7,    3'b011, 1'b1};
    tbl[14] = '{-1,   3'b001, 1'b1};
    tbl[15] = '{63,   3'b010, 1'b1};
    tbl[16] = '{64,   3'b010, 1'b0};
    // PAM-8, separation 32, binary: thresholds -96,-64,-32,0,32,64,96.
    tbl8[0] = '{-112, 3'b000, 1'b0};
    tbl8[1] = '{-16,  3'b011, 1'b0};
    tbl8[2] = '{16,   3'b100, 1'b0};
    tbl8[3] = '{112,  3'b111, 1'b0};
    tbl8[4] = '{0,    3'b100, 1'b1};
    tbl8[5] = '{-1,   3'b011, 1'b1};

    rst = 1'b1; vin = '0; in_valid = 1'b0; out_ready = 1'b0; count_clear = 1'b0;
    vin8 = '0; in_valid8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_symbol", 32'(sym_out), 32'd0);
    check("rst_low_margin", 32'(lm_out), 32'd0);
    check("rst_margin_count", 32'(mcount), 32'd0);
    rst = 1'b0;
    check("ready_held_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Back-to-back nominal levels: valid rises on the edge after the accept edge.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(tbl[i], 1'b0);
      if (i == 0) check("latency_not_yet", 32'(out_valid), 32'd0);
      else        check("stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_tail", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("stream_done", 32'(out_valid), 32'd0);
    drain();

    // Threshold/saturation vectors and margin counting.
    clear_count();
    for (int i = 4; i < 9; i++) send(tbl[i], 1'b0);
    in_valid = 1'b0;
    drain();
    check("margin_count_3", 32'(mcount), 32'd3);
    exp_lm = 3;
    for (int i = 9; i < 17; i++) begin
      send(tbl[i], 1'b0);
      exp_lm += int'(tbl[i].lm);
    end
    in_valid = 1'b0;
    drain();
    check("margin_count_edges", 32'(mcount), 32'(exp_lm));

    // Whole table under random output backpressure.
    clear_count();
    exp_lm = 0;
    for (int i = 0; i < 17; i++) begin
      send(tbl[i], 1'b1);
      exp_lm += int'(tbl[i].lm);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("margin_count_random", 32'(mcount), 32'(exp_lm));

    // Full buffer: six offered with output stalled, four fit.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      vin = tbl[4 + i].vin; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        q4.push_back('{sym: tbl[4 + i].sym, lm: tbl[4 + i].lm});
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("accepted_when_full", 32'(acc), 32'd4);
    check("ready_when_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    drain();
    check("ready_after_drain", 32'(in_ready), 32'd1);

    // Saturation at FFFF, then clear wins over a simultaneous low-margin pop.
    @(negedge clk);
    force dut.r_margin_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_margin_count;
    check("preload_ffff", 32'(mcount), 32'hFFFF);
    send(tbl[5], 1'b0);
    in_valid = 1'b0;
    drain();
    check("margin_saturated", 32'(mcount), 32'hFFFF);
    out_ready = 1'b0;
    send(tbl[6], 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("one_buffered", 32'(out_valid), 32'd1);
    count_clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    count_clear = 1'b0;
    check("clear_priority", 32'(mcount), 32'd0);
    check("popped_with_clear", 32'(out_valid), 32'd0);

    // Mid-stream reset with three symbols buffered.
    send(tbl[5], 1'b0);
    in_valid = 1'b0;
    drain();
    check("margin_count_1", 32'(mcount), 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(tbl[6 + i], 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("three_buffered", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_symbol", 32'(sym_out), 32'd0);
    check("midrst_margin_count", 32'(mcount), 32'd0);
    rst = 1'b0;
    q4.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_stale_symbol", 32'(out_valid), 32'd0);
    end
    check("ready_after_midrst", 32'(in_ready), 32'd1);

    // PAM-8 binary instance.
    for (int i = 0; i < 6; i++) begin
      vin8 = tbl8[i].vin; in_valid8 = 1'b1;
      @(negedge clk);
      if (in_ready8) q8.push_back('{sym: tbl8[i].sym, lm: tbl8[i].lm});
      else check("pam8_ready", 32'(in_ready8), 32'd1);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pam8_drained", 32'(q8.size()), 32'd0);
    check("pam8_margin_count", 32'(mcount8), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
